// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths and ALU opcode encodings.
package cpu_defs;

    localparam int DATA_WIDTH = 32;
    localparam int REG_AW     = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/operand_bypass.sv
// Combinational operand resolve for one source register against the MEM and
// WB producers. MEM has priority; a MEM load without data yet marks pending.
module operand_bypass
    import cpu_defs::*;
#(
    parameter int DW = cpu_defs::DATA_WIDTH,
    parameter int AW = cpu_defs::REG_AW
) (
    input  logic [AW-1:0] rs,
    input  logic [DW-1:0] stored,
    input  logic          mem_valid,
    input  logic          mem_wen,
    input  logic          mem_is_load,
    input  logic          mem_data_ok,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_valid,
    input  logic          wb_wen,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] value,
    output logic          pending
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero in the regfile, so it never takes a forward
    assign mem_hit = mem_valid & mem_wen & (mem_rd == rs) & (rs != '0);
    assign wb_hit  = wb_valid  & wb_wen  & (wb_rd  == rs) & (rs != '0);

    // Youngest producer wins; an unfinished load blocks the operand
    always_comb begin
        value   = stored;
        pending = 1'b0;
        if (mem_hit) begin
            if (mem_is_load & ~mem_data_ok) pending = 1'b1;
            else                            value   = mem_data;
        end else if (wb_hit) begin
            value = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: single-entry valid/ready stage that keeps
// resolving its operands through MEM/WB bypass while held, and stalls on a
// load-use hazard until the load data arrives.
module alu_operand_stage
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH = cpu_defs::DATA_WIDTH,
    parameter int REG_AW     = cpu_defs::REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_AW-1:0]     in_rs1,
    input  logic [REG_AW-1:0]     in_rs2,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [DATA_WIDTH-1:0] in_rs2_val,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  in_use_imm,
    input  logic [2:0]            in_alu_op,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic                  mem_valid,
    input  logic                  mem_wen,
    input  logic                  mem_is_load,
    input  logic                  mem_data_ok,
    input  logic [REG_AW-1:0]     mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wb_valid,
    input  logic                  wb_wen,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_A,
    output logic [DATA_WIDTH-1:0] out_B,
    output logic [2:0]            out_alu_op,
    output logic [REG_AW-1:0]     out_rd,
    output logic                  out_wen,
    output logic                  out_is_load
);

    logic                  entry_valid;
    logic [REG_AW-1:0]     rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_b_q, imm_q;
    logic                  use_imm_q, wen_q, is_load_q;
    logic [2:0]            alu_op_q;

    logic [DATA_WIDTH-1:0] res_a, res_b;
    logic                  pend_a, pend_b_raw, pend_b;
    logic                  fire_out, accept;
    logic                  wb_hit_rs1, wb_hit_rs2;
    logic [DATA_WIDTH-1:0] cap_a, cap_b;

    operand_bypass #(.DW(DATA_WIDTH), .AW(REG_AW)) u_byp_a (
        .rs(rs1_q), .stored(op_a_q),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_data_ok(mem_data_ok), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .value(res_a), .pending(pend_a)
    );

    operand_bypass #(.DW(DATA_WIDTH), .AW(REG_AW)) u_byp_b (
        .rs(rs2_q), .stored(op_b_q),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_data_ok(mem_data_ok), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .value(res_b), .pending(pend_b_raw)
    );

    // Immediate B operand never depends on rs2, so it cannot stall
    assign pend_b      = pend_b_raw & ~use_imm_q;
    assign out_valid   = entry_valid & ~pend_a & ~pend_b;
    assign fire_out    = out_valid & out_ready;
    assign in_ready    = ~entry_valid | fire_out;
    assign accept      = in_valid & in_ready & ~flush;

    assign out_A       = res_a;
    assign out_B       = use_imm_q ? imm_q : res_b;
    assign out_alu_op  = alu_op_q;
    assign out_rd      = rd_q;
    assign out_wen     = wen_q;
    assign out_is_load = is_load_q;

    // At capture only WB is taken; a MEM producer is picked up once held
    assign wb_hit_rs1 = wb_valid & wb_wen & (wb_rd == in_rs1) & (in_rs1 != '0);
    assign wb_hit_rs2 = wb_valid & wb_wen & (wb_rd == in_rs2) & (in_rs2 != '0);
    assign cap_a      = wb_hit_rs1 ? wb_data : in_rs1_val;
    assign cap_b      = wb_hit_rs2 ? wb_data : in_rs2_val;

    // Entry register: reset, flush, capture, drain, or refresh while held
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            wen_q       <= 1'b0;
            is_load_q   <= 1'b0;
            alu_op_q    <= '0;
        end else if (flush) begin
            entry_valid <= 1'b0;
        end else if (accept) begin
            entry_valid <= 1'b1;
            rs1_q       <= in_rs1;
            rs2_q       <= in_rs2;
            rd_q        <= in_rd;
            op_a_q      <= cap_a;
            op_b_q      <= cap_b;
            imm_q       <= in_imm;
            use_imm_q   <= in_use_imm;
            wen_q       <= in_wen;
            is_load_q   <= in_is_load;
            alu_op_q    <= in_alu_op;
        end else if (fire_out) begin
            entry_valid <= 1'b0;
        end else if (entry_valid) begin
            // Latch forwarded data so it outlives the producer leaving MEM/WB
            if (!pend_a) op_a_q <= res_a;
            if (!pend_b) op_b_q <= res_b;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, plain issue, MEM/WB bypass,
// load-use stall, x0/immediate, flush, reset mid-stall and back-to-back flow.
module tb_alu_operand_stage;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd, mem_rd, wb_rd, out_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, mem_data, wb_data, out_A, out_B;
    logic        in_use_imm, in_wen, in_is_load;
    logic [2:0]  in_alu_op, out_alu_op;
    logic        mem_valid, mem_wen, mem_is_load, mem_data_ok, wb_valid, wb_wen;
    logic        out_valid, out_ready, out_wen, out_is_load;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
        .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_data_ok(mem_data_ok), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .out_alu_op(out_alu_op),
        .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load)
    );

    // Advance one clock, then settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_val = 0; in_rs2_val = 0;
        in_imm = 0; in_use_imm = 0; in_alu_op = 0; in_rd = 0; in_wen = 0; in_is_load = 0;
        mem_valid = 0; mem_wen = 0; mem_is_load = 0; mem_data_ok = 0; mem_rd = 0; mem_data = 0;
        wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic [31:0] v2,
                         input logic [2:0] op, input logic [4:0] rd);
        in_valid = 1; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2; in_rs2_val = v2;
        in_alu_op = op; in_rd = rd; in_wen = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL reset_out_A got=%h exp=0", out_A); end
        checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL reset_out_B got=%h exp=0", out_B); end
        rst = 0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        idle();
        offer(5'd1, 32'd5, 5'd2, 32'd7, ALU_ADD, 5'd10);
        out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_not_early got=%b exp=0", out_valid); end
        tick();
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (out_A !== 32'd5) begin errors++; $display("FAIL add_A got=%h exp=5", out_A); end
        checks++; if (out_B !== 32'd7) begin errors++; $display("FAIL add_B got=%h exp=7", out_B); end
        checks++; if (out_alu_op !== 3'b000) begin errors++; $display("FAIL add_op got=%b exp=000", out_alu_op); end
        checks++; if (out_rd !== 5'd10 || out_wen !== 1'b1) begin errors++; $display("FAIL add_rd got=%0d/%b exp=10/1", out_rd, out_wen); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_one_cycle got=%b exp=0", out_valid); end
    endtask

    task automatic test_mem_bypass();
        idle();
        // WB match on rs2 during capture is folded into the stored value
        offer(5'd3, 32'd1, 5'd5, 32'd2, ALU_SUB, 5'd11);
        wb_valid = 1; wb_wen = 1; wb_rd = 5'd5; wb_data = 32'h55;
        tick();
        in_valid = 0; wb_valid = 0; wb_wen = 0;
        mem_valid = 1; mem_wen = 1; mem_rd = 5'd3; mem_data = 32'h20;
        #1;
        checks++; if (out_A !== 32'h20) begin errors++; $display("FAIL mem_byp_A got=%h exp=20", out_A); end
        checks++; if (out_B !== 32'h55) begin errors++; $display("FAIL wb_capture_B got=%h exp=55", out_B); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mem_byp_valid got=%b exp=1", out_valid); end
        tick();
        mem_valid = 0; mem_wen = 0;
        #1;
        checks++; if (out_A !== 32'h20) begin errors++; $display("FAIL mem_refresh_A got=%h exp=20", out_A); end
        tick();
        checks++; if (out_A !== 32'h20) begin errors++; $display("FAIL mem_refresh_A2 got=%h exp=20", out_A); end
        out_ready = 1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mem_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_load_use();
        idle();
        offer(5'd6, 32'h11, 5'd4, 32'h22, ALU_OR, 5'd12);
        out_ready = 1;
        mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_rd = 5'd4; mem_data = 32'hDEAD;
        tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++; $display("FAIL load_use_stall cyc=%0d got=%b/%b exp=0/0", i, out_valid, in_ready); end
            tick();
        end
        mem_data_ok = 1; mem_data = 32'hBEEF; out_ready = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load_use_release got=%b exp=1", out_valid); end
        checks++; if (out_B !== 32'hBEEF) begin errors++; $display("FAIL load_use_B got=%h exp=beef", out_B); end
        checks++; if (out_A !== 32'h11) begin errors++; $display("FAIL load_use_A got=%h exp=11", out_A); end
        tick();
        mem_valid = 0; mem_wen = 0; mem_is_load = 0; mem_data_ok = 0;
        #1;
        checks++; if (out_B !== 32'hBEEF) begin errors++; $display("FAIL load_refresh_B got=%h exp=beef", out_B); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_x0_imm();
        idle();
        offer(5'd0, 32'h0, 5'd8, 32'h33, ALU_ADD, 5'd13);
        in_use_imm = 1; in_imm = 32'hFFFFFFFC;
        wb_valid = 1; wb_wen = 1; wb_rd = 5'd0; wb_data = 32'h77;
        tick();
        in_valid = 0; wb_valid = 0; wb_wen = 0;
        mem_valid = 1; mem_wen = 1; mem_rd = 5'd0; mem_data = 32'd9;
        #1;
        checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL x0_no_forward got=%h exp=0", out_A); end
        mem_rd = 5'd8; mem_is_load = 1; mem_data_ok = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL imm_no_stall got=%b exp=1", out_valid); end
        checks++; if (out_B !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm_B got=%h exp=fffffffc", out_B); end
        out_ready = 1;
        tick();
        // MEM has priority over WB for the same register
        idle();
        offer(5'd7, 32'h1, 5'd9, 32'h2, ALU_XOR, 5'd14);
        tick();
        in_valid = 0;
        mem_valid = 1; mem_wen = 1; mem_rd = 5'd7; mem_data = 32'hA;
        wb_valid = 1; wb_wen = 1; wb_rd = 5'd7; wb_data = 32'hB;
        #1;
        checks++; if (out_A !== 32'hA) begin errors++; $display("FAIL mem_over_wb got=%h exp=a", out_A); end
        mem_valid = 0;
        #1;
        checks++; if (out_A !== 32'hB) begin errors++; $display("FAIL wb_held got=%h exp=b", out_A); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_flush();
        idle();
        offer(5'd1, 32'h1, 5'd2, 32'h2, ALU_AND, 5'd15);
        tick();
        offer(5'd3, 32'h99, 5'd4, 32'h98, ALU_MUL, 5'd16);
        flush = 1; out_ready = 1;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_not_masked got=%b exp=1", out_valid); end
        tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty got=%b/%b exp=0/1", out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        offer(5'd6, 32'h44, 5'd4, 32'h45, ALU_SLT, 5'd17);
        mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_rd = 5'd6;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_before_rst got=%b exp=0", out_valid); end
        rst = 1;
        tick();
        rst = 0; mem_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_A !== 32'h0) begin
            errors++; $display("FAIL rst_mid_stall got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_A); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        idle();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            op = 3'(i);
            offer(5'd1, 32'h100 + i, 5'd2, 32'h200 + i, op, 5'd20);
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_flow i=%0d got=%b/%b exp=1/1", i, out_valid, in_ready); end
            checks++; if (out_A !== 32'h100 + i || out_B !== 32'h200 + i || out_alu_op !== op) begin
                errors++; $display("FAIL b2b_data i=%0d got=%h/%h/%b exp=%h/%h/%b", i, out_A, out_B,
                                   out_alu_op, 32'h100 + i, 32'h200 + i, op); end
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_add();
        test_mem_bypass();
        test_load_use();
        test_x0_imm();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
